// File: rtl/dm_delay_line_ctrl.sv
// Tap controller for an IOD delay line: steps the tap with gap-spaced MOVE
// pulses, reloads it, or pulses the lane sync resets, one command at a time.
module dm_delay_line_ctrl #(
  parameter int TAP_MAX     = 127,
  parameter int LOAD_TAP    = 1,
  parameter int MOVE_GAP    = 3,
  parameter int SYNC_CYCLES = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [7:0] CMD_COUNT,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic       TX_SYNC_RST,
  output logic       RX_SYNC_RST,
  output logic [7:0] TAP_POS,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [7:0] TAP_MAX_L  = 8'(TAP_MAX);
  localparam logic [7:0] LOAD_TAP_L = 8'(LOAD_TAP);
  localparam logic [3:0] GAP_LAST   = 4'(MOVE_GAP - 1);
  localparam logic [3:0] SYNC_LAST  = 4'(SYNC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MOVE, S_GAP, S_LOAD, S_SYNC, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tap_q, tap_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] timer_q, timer_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic       rst_hold_q;
  logic       sync_d;

  // A step that would leave the legal tap range is refused rather than issued.
  function automatic logic at_bound(input logic inc, input logic [7:0] tap);
    return inc ? (tap == TAP_MAX_L) : (tap == 8'd0);
  endfunction

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q    <= S_IDLE;
      tap_q      <= LOAD_TAP_L;
      cnt_q      <= 8'd0;
      timer_q    <= 4'd0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      rst_hold_q <= 1'b0;
    end
  end

  always_comb begin
    state_d         = state_q;
    tap_d           = tap_q;
    cnt_d           = cnt_q;
    timer_d         = timer_q;
    dir_d           = dir_q;
    err_d           = err_q;
    sync_d          = 1'b0;
    CMD_READY       = 1'b0;
    DELAY_LINE_MOVE = 1'b0;
    DELAY_LINE_LOAD = 1'b0;
    DONE            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          cnt_d = CMD_COUNT;
          err_d = 1'b0;
          unique case (CMD_OP)
            2'b00: state_d = S_LOAD;
            2'b01: begin dir_d = 1'b1; state_d = S_SETUP; end
            2'b10: begin dir_d = 1'b0; state_d = S_SETUP; end
            default: begin timer_d = SYNC_LAST; state_d = S_SYNC; end
          endcase
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else if (at_bound(dir_q, tap_q)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        DELAY_LINE_MOVE = 1'b1;
        tap_d   = dir_q ? tap_q + 8'd1 : tap_q - 8'd1;
        cnt_d   = cnt_q - 8'd1;
        timer_d = GAP_LAST;
        state_d = S_GAP;
      end
      S_GAP: begin
        // Only the final gap cycle samples the IOD range flag.
        if (timer_q != 4'd0) begin
          timer_d = timer_q - 4'd1;
        end else if (DELAY_LINE_OUT_OF_RANGE) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else if (at_bound(dir_q, tap_q)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_LOAD: begin
        DELAY_LINE_LOAD = 1'b1;
        tap_d   = LOAD_TAP_L;
        state_d = S_DONE;
      end
      S_SYNC: begin
        sync_d = 1'b1;
        if (timer_q == 4'd0) state_d = S_DONE;
        else                 timer_d = timer_q - 4'd1;
      end
      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sync resets stay up from reset assertion until the first clock after release.
  assign TX_SYNC_RST          = sync_d | rst_hold_q;
  assign RX_SYNC_RST          = sync_d | rst_hold_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign TAP_POS              = tap_q;
  assign ERR                  = err_q;

endmodule

// File: tb/tb_dm_delay_line_ctrl.sv
// Randomized scoreboard bench for dm_delay_line_ctrl with a command-level model.
module tb_dm_delay_line_ctrl;
  localparam int TAP_MAX = 127, LOAD_TAP = 1, MOVE_GAP = 3, SYNC_CYCLES = 4;
  localparam int P = 1 + MOVE_GAP;

  logic FAB_CLK = 1'b0, ARST = 1'b1, CMD_VALID = 1'b0, CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [7:0] CMD_COUNT = 8'd0;
  logic DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
  logic TX_SYNC_RST, RX_SYNC_RST, DONE, ERR;
  logic [7:0] TAP_POS;

  dm_delay_line_ctrl #(.TAP_MAX(TAP_MAX), .LOAD_TAP(LOAD_TAP), .MOVE_GAP(MOVE_GAP),
                       .SYNC_CYCLES(SYNC_CYCLES)) dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_COUNT(CMD_COUNT),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .TX_SYNC_RST(TX_SYNC_RST), .RX_SYNC_RST(RX_SYNC_RST), .TAP_POS(TAP_POS),
    .DONE(DONE), .ERR(ERR));

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  typedef struct {
    int t; int op; int lat; int tap; int err; int moves; int dir;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int model_tap = LOAD_TAP;
  int mv = 0, ld = 0, sy = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", name, got, want, cyc);
    end
  endtask

  // Command-level reference: walk the requested steps and stop on a bound or range error.
  function automatic exp_t model(input int op, input int n, input int oor_k, input int t);
    exp_t e;
    e.t = t; e.op = op; e.err = 0; e.moves = 0; e.dir = (op == 1);
    case (op)
      0: begin model_tap = LOAD_TAP; e.lat = 2; end
      3: e.lat = 1 + SYNC_CYCLES;
      default: begin
        for (int i = 0; i < n; i++) begin
          if ((op == 1 && model_tap == TAP_MAX) || (op == 2 && model_tap == 0)) begin
            e.err = 1; break;
          end
          model_tap += (op == 1) ? 1 : -1;
          e.moves++;
          if (e.moves == oor_k) begin e.err = 1; break; end
        end
        e.lat = 2 + e.moves * P;
      end
    endcase
    e.tap = model_tap;
    return e;
  endfunction

  // Monitor: attributes every pulse to the command at the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge FAB_CLK);
      if (ARST) begin
        q.delete(); mv = 0; ld = 0; sy = 0;
      end else begin
        if (DELAY_LINE_MOVE) begin
          if (q.size() == 0) chk("move_unexpected", 1, 0);
          else begin
            chk("move_cycle", cyc, q[0].t + 2 + mv * P);
            chk("move_dir", DELAY_LINE_DIRECTION, q[0].dir);
          end
          mv++;
        end
        if (DELAY_LINE_LOAD) begin
          if (q.size() == 0) chk("load_unexpected", 1, 0);
          else chk("load_cycle", cyc, q[0].t + 1);
          ld++;
        end
        if (TX_SYNC_RST || RX_SYNC_RST) begin
          chk("sync_pair", RX_SYNC_RST, TX_SYNC_RST);
          if (q.size() == 0) chk("sync_unexpected", 1, 0);
          else chk("sync_window", (cyc >= q[0].t + 1 && cyc <= q[0].t + SYNC_CYCLES), 1);
          sy++;
        end
        if (DONE) begin
          if (q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("done_latency", cyc - e.t, e.lat);
            chk("done_tap", TAP_POS, e.tap);
            chk("done_err", ERR, e.err);
            chk("done_moves", mv, e.moves);
            chk("done_loads", ld, (e.op == 0) ? 1 : 0);
            chk("done_sync_cycles", sy, (e.op == 3) ? SYNC_CYCLES : 0);
          end
          mv = 0; ld = 0; sy = 0;
        end
      end
    end
  end

  task automatic send(input int op, input int n, input int oor_k, output int t);
    int k = 0;
    while (!CMD_READY && k < 100) begin @(negedge FAB_CLK); k++; end
    if (!CMD_READY) chk("ready_timeout", 0, 1);
    CMD_VALID = 1'b1; CMD_OP = 2'(op); CMD_COUNT = 8'(n);
    t = cyc;
    q.push_back(model(op, n, oor_k, t));
    @(negedge FAB_CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int t, input int oor_k);
    bit seen = 0;
    for (int k = 0; k < 3000; k++) begin
      if (DONE) begin seen = 1; break; end
      if (oor_k > 0 && cyc >= t + 3 + (oor_k - 1) * P && cyc <= t + 1 + oor_k * P)
        DELAY_LINE_OUT_OF_RANGE = 1'b1;
      else if (cyc == t + 1 || (cyc >= t + 2 && (cyc - t - 2) % P == 0))
        DELAY_LINE_OUT_OF_RANGE = 1'($urandom_range(0, 1));
      else
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
      CMD_VALID = 1'($urandom_range(0, 1));
      CMD_OP    = 2'($urandom_range(0, 3));
      CMD_COUNT = 8'($urandom_range(0, 255));
      @(negedge FAB_CLK);
    end
    if (!seen) chk("done_timeout", 0, 1);
    CMD_VALID = 1'b0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
  endtask

  task automatic run(input int op, input int n, input int oor_k);
    int t;
    send(op, n, oor_k, t);
    wait_done(t, oor_k);
  endtask

  initial begin
    int t, op, n, ok;
    @(negedge FAB_CLK);
    chk("rst_ready", CMD_READY, 1);
    chk("rst_move", DELAY_LINE_MOVE, 0);
    chk("rst_load", DELAY_LINE_LOAD, 0);
    chk("rst_dir", DELAY_LINE_DIRECTION, 0);
    chk("rst_tx_sync", TX_SYNC_RST, 1);
    chk("rst_rx_sync", RX_SYNC_RST, 1);
    chk("rst_tap", TAP_POS, LOAD_TAP);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    #2 ARST = 1'b0;
    #1 chk("sync_held_until_edge", TX_SYNC_RST, 1);
    @(negedge FAB_CLK);
    chk("rel_tx_sync", TX_SYNC_RST, 0);
    chk("rel_rx_sync", RX_SYNC_RST, 0);
    chk("rel_ready", CMD_READY, 1);

    run(1, 3, 0);              // INC 3 from 1: moves at t+2/6/10, done t+14, tap 4
    run(0, 0, 0);
    run(2, 5, 0);              // DEC 5 from 1: one move then bound error
    run(1, 10, 2);             // range flag in second gap: two moves, error
    run(1, 38, 0);             // tap to 40
    run(0, 0, 0);              // LOAD back to 1
    run(3, 0, 0);              // SYNC pulse

    // Abort an INC 8 during its first gap.
    send(1, 8, 0, t);
    repeat (2) @(negedge FAB_CLK);
    ARST = 1'b1;
    #1;
    chk("abort_move", DELAY_LINE_MOVE, 0);
    chk("abort_ready", CMD_READY, 1);
    chk("abort_tap", TAP_POS, LOAD_TAP);
    chk("abort_done", DONE, 0);
    repeat (2) begin @(negedge FAB_CLK); chk("abort_no_done", DONE, 0); end
    #2 ARST = 1'b0;
    model_tap = LOAD_TAP;
    run(1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      n  = $urandom_range(0, 20);
      ok = 0;
      if ((op == 1 || op == 2) && n > 0 && $urandom_range(0, 3) == 0) ok = $urandom_range(1, n);
      run(op, n, ok);
    end
    run(1, 255, 0);            // runs into TAP_MAX
    run(2, 255, 0);            // runs down to 0

    repeat (3) @(negedge FAB_CLK);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_delay_line_ctrl.md
DM_DELAY_LINE_CTRL -- requirements
Module: dm_delay_line_ctrl

Interface
REQ-001 SHALL have parameter TAP_MAX, default 127: highest legal tap position.
REQ-002 SHALL have parameter LOAD_TAP, default 1: tap position after a LOAD; equals the lane's static TX delay value.
REQ-003 SHALL have parameter MOVE_GAP, default 3: idle cycles after each DELAY_LINE_MOVE pulse; legal range 1..15.
REQ-004 SHALL have parameter SYNC_CYCLES, default 4: sync-reset pulse width in cycles; legal range 1..15.
REQ-005 SHALL have port FAB_CLK, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port ARST, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port CMD_VALID, input, 1: command request.
REQ-008 SHALL have port CMD_READY, output, 1: command accepted when CMD_VALID and CMD_READY are both high.
REQ-009 SHALL have port CMD_OP, input, 2: 00 LOAD, 01 INC, 10 DEC, 11 SYNC.
REQ-010 SHALL have port CMD_COUNT, input, 8: number of taps to move for INC/DEC.
REQ-011 SHALL have port DELAY_LINE_OUT_OF_RANGE, input, 1: out-of-range flag from the IOD.
REQ-012 SHALL have port DELAY_LINE_MOVE, output, 1: one-cycle tap step pulse to the IOD.
REQ-013 SHALL have port DELAY_LINE_DIRECTION, output, 1: 1 = increment, 0 = decrement.
REQ-014 SHALL have port DELAY_LINE_LOAD, output, 1: one-cycle reload pulse to the IOD.
REQ-015 SHALL have ports TX_SYNC_RST and RX_SYNC_RST, output, 1 each: lane synchronous resets.
REQ-016 SHALL have port TAP_POS, output, 8: tracked tap position.
REQ-017 SHALL have port DONE, output, 1: one-cycle command-complete pulse.
REQ-018 SHALL have port ERR, output, 1: status of the last completed command.

Function
REQ-019 SHALL implement states IDLE, SETUP, MOVE, GAP, LOAD, SYNC and DONE.
REQ-020 SHALL drive CMD_READY high only in IDLE; on accept, latch CMD_OP and CMD_COUNT, clear ERR, and go to LOAD (op 00), SETUP (op 01/10) or SYNC (op 11).
REQ-021 SHALL, for INC/DEC with CMD_COUNT = 0, go SETUP->DONE without any MOVE pulse.
REQ-022 SHALL, in SETUP (one cycle), drive DELAY_LINE_DIRECTION from the op and hold it until the next accepted INC/DEC; DELAY_LINE_MOVE is low in SETUP.
REQ-023 SHALL, before each pulse, check the bound: INC with TAP_POS = TAP_MAX or DEC with TAP_POS = 0 skips the pulse, sets ERR and goes to DONE.
REQ-024 SHALL, in MOVE, assert DELAY_LINE_MOVE for exactly one cycle, update TAP_POS by +/-1 on the next edge, decrement the remaining count, and then go to GAP.
REQ-025 SHALL hold GAP for MOVE_GAP cycles, then evaluate in priority order:
- DELAY_LINE_OUT_OF_RANGE high on the last GAP cycle -> set ERR, go to DONE;
- remaining count = 0 -> go to DONE;
- otherwise -> bound check, then MOVE.
REQ-026 SHALL set INC/DEC latency from accept cycle t to DONE high at t+2+N*(1+MOVE_GAP) for N unobstructed moves.
REQ-027 SHALL, in LOAD (one cycle), pulse DELAY_LINE_LOAD and set TAP_POS to LOAD_TAP, then go to DONE.
REQ-028 SHALL, in SYNC, hold TX_SYNC_RST and RX_SYNC_RST high together for SYNC_CYCLES cycles, then go to DONE; TAP_POS is unchanged.
REQ-029 SHALL, in DONE (one cycle), assert DONE with ERR valid and return to IDLE; ERR holds until the next accept.
REQ-030 SHALL ignore CMD_OP and CMD_COUNT changes while CMD_READY is low.
REQ-031 SHALL ignore DELAY_LINE_OUT_OF_RANGE outside GAP.

Reset
REQ-032 SHALL, while ARST is high, force state IDLE and set:
- CMD_READY=1;
- DELAY_LINE_MOVE=0, DELAY_LINE_LOAD=0, DELAY_LINE_DIRECTION=0;
- TX_SYNC_RST=1, RX_SYNC_RST=1;
- TAP_POS=LOAD_TAP, DONE=0, ERR=0.
REQ-033 SHALL release TX_SYNC_RST and RX_SYNC_RST on the first FAB_CLK edge after ARST deasserts.
REQ-034 SHALL, on ARST mid-command, abort immediately with no DONE pulse and no partial-pulse completion.

Verification
REQ-035 SHALL cover reset: ARST high -> every output at its REQ-032 value; first edge after release -> both sync resets 0, CMD_READY 1.
REQ-036 SHALL cover INC 3 from TAP_POS 1, defaults, accept at t -> MOVE high at t+2, t+6 and t+10; DIRECTION 1; DONE at t+14; TAP_POS 4; ERR 0.
REQ-037 SHALL cover DEC 5 from TAP_POS 1 -> exactly one MOVE pulse; TAP_POS 0; DONE with ERR 1.
REQ-038 SHALL cover INC 10 with OUT_OF_RANGE forced high during the second GAP -> two pulses; DONE with ERR 1; TAP_POS +2.
REQ-039 SHALL cover LOAD after TAP_POS 40 -> single DELAY_LINE_LOAD pulse at t+1, TAP_POS 1, DONE at t+2; then SYNC -> both sync resets high for exactly 4 cycles, DONE on the following cycle.
REQ-040 SHALL cover ARST asserted during GAP of INC 8 -> MOVE low, state IDLE, TAP_POS 1, no DONE; a new INC 1 after release completes normally.
